// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the execution units and the register-file write-back arbiter.
//   req_valid/req_adr/req_data : one result per requester (adr slice [5i+4:5i], data [32i+31:32i])
//   req_ready                  : one-hot accept, combinational
//   hold                       : blocks all grants this cycle
//   issue_valid/issue_adr      : destination register of an issuing instruction
//   wend/write_adr/write_data  : registered register-file write port
//   busy                       : per-register in-flight scoreboard
// master = requesters/issue side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_adr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               hold;
    logic               issue_valid;
    logic [4:0]         issue_adr;
    logic               wend;
    logic [4:0]         write_adr;
    logic [31:0]        write_data;
    logic [31:0]        busy;

    modport master (
        output req_valid, req_adr, req_data, hold, issue_valid, issue_adr,
        input  req_ready, wend, write_adr, write_data, busy
    );

    modport slave (
        input  req_valid, req_adr, req_data, hold, issue_valid, issue_adr,
        output req_ready, wend, write_adr, write_data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter and busy scoreboard for the 32x32 register file.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   wb    : write-back bus (slave side), see regfile_wb_arbiter_if
// One requester is granted per cycle starting the search at r_rr_ptr; the winner is
// captured into a registered write slot that drives the register-file write port in
// the following cycle. busy[r] is set on issue and cleared on the committing write.
// NREQ must match the NREQ of the connected interface instance (2..8).
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave wb
);
    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]   r_rr_ptr;
    logic            r_wend;
    logic [4:0]      r_write_adr;
    logic [31:0]     r_write_data;
    logic [31:0]     r_busy;

    logic            w_grant_vld;
    logic [PW-1:0]   w_grant_idx;
    logic [NREQ-1:0] w_ready;
    logic [4:0]      w_sel_adr;
    logic [31:0]     w_sel_data;
    logic [PW-1:0]   w_ptr_next;
    logic [31:0]     w_busy_d;

    // Rotating priority search; req_ready is forced low while in reset.
    always_comb begin
        int unsigned idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_ready     = '0;
        idx         = 0;
        if (rst_n && !wb.hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(r_rr_ptr) + k) % NREQ;
                if (!w_grant_vld && wb.req_valid[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = PW'(idx);
                end
            end
            if (w_grant_vld) begin
                w_ready[w_grant_idx] = 1'b1;
            end
        end
    end

    assign wb.req_ready = w_ready;

    always_comb begin
        w_sel_adr  = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PW'(i) == w_grant_idx) begin
                w_sel_adr  = wb.req_adr[5*i +: 5];
                w_sel_data = wb.req_data[32*i +: 32];
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // Clear on commit first so that a same-edge issue to the same register wins.
    always_comb begin
        w_busy_d = r_busy;
        if (r_wend) begin
            w_busy_d[r_write_adr] = 1'b0;
        end
        if (wb.issue_valid && (wb.issue_adr != 5'd0)) begin
            w_busy_d[wb.issue_adr] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_wend       <= 1'b0;
            r_write_adr  <= '0;
            r_write_data <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_d;
            // A grant to x0 is accepted and loads the slot, but never writes.
            r_wend <= w_grant_vld && (w_sel_adr != 5'd0);
            if (w_grant_vld) begin
                r_rr_ptr     <= w_ptr_next;
                r_write_adr  <= w_sel_adr;
                r_write_data <= w_sel_data;
            end
        end
    end

    assign wb.wend       = r_wend;
    assign wb.write_adr  = r_write_adr;
    assign wb.write_data = r_write_data;
    assign wb.busy       = r_busy;
endmodule
